// File: rtl/tpu_host_driver.sv
// tpu_host_driver: byte-stream host front end for a TPU (weight/input/instruction loads, run, result capture).
// Define TPU_HOST_DRIVER_RESULT_EN to build the WAIT/CAPTURE path and the result FIFO.
module tpu_host_driver #(
  parameter int RESULT_DEPTH = 8,
  parameter int CAPTURE_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] ui_out,
  output logic       fetch_w,
  output logic       fetch_inp,
  output logic       fetch_ins,
  output logic       start,
  input  logic [7:0] tpu_out,
  output logic [7:0] r_data,
  output logic       r_valid,
  input  logic       r_ready,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CAPTURE} state_t;
  state_t state, nxt;
  logic [1:0] op;
  logic [5:0] cnt;
  logic acc;
  logic unused;
  assign acc = s_valid && s_ready;
`ifdef TPU_HOST_DRIVER_RESULT_EN
  localparam int AW = $clog2(RESULT_DEPTH);
  logic [3:0] dly;
  logic [7:0] mem [RESULT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, full, wr_en;
  assign unused = s_data[5];
`else
  assign unused = ^{s_data[5], tpu_out, r_ready, 1'(RESULT_DEPTH), 1'(CAPTURE_DELAY)};
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? ((s_data[7:6] == 2'b11) ? START : LOAD) : IDLE;
      LOAD:    nxt = (acc && cnt == 6'd1) ? IDLE : LOAD;
`ifdef TPU_HOST_DRIVER_RESULT_EN
      START:   nxt = (CAPTURE_DELAY == 1) ? CAPTURE : WAIT;
      WAIT:    nxt = (dly == 4'd1) ? CAPTURE : WAIT;
      CAPTURE: nxt = (cnt == 6'd1) ? IDLE : CAPTURE;
`else
      START:   nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    s_ready = (state == IDLE) || (state == LOAD);
    start = state == START;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= '0;
      cnt <= '0;
      ui_out <= '0;
      fetch_w <= 1'b0;
      fetch_inp <= 1'b0;
      fetch_ins <= 1'b0;
    end else begin
      fetch_w <= state == LOAD && acc && op == 2'b00;
      fetch_inp <= state == LOAD && acc && op == 2'b01;
      fetch_ins <= state == LOAD && acc && op == 2'b10;
      if (state == LOAD && acc) ui_out <= s_data;
      if (state == IDLE && acc) begin
        op <= s_data[7:6];
        cnt <= {1'b0, s_data[4:0]} + 6'd1;
      end else if ((state == LOAD && acc) || state == CAPTURE) cnt <= cnt - 6'd1;
    end
  end
`ifdef TPU_HOST_DRIVER_RESULT_EN
  // dly counts the WAIT cycles left so the first CAPTURE cycle is CAPTURE_DELAY after START
  always_ff @(posedge clk)
    if (reset) dly <= '0;
    else if (state == START) dly <= 4'(CAPTURE_DELAY - 1);
    else if (state == WAIT) dly <= dly - 4'd1;
  assign push = state == CAPTURE;
  assign r_valid = count != '0;
  assign pop = r_valid && r_ready;
  assign full = count == (AW + 1)'(RESULT_DEPTH);
  assign wr_en = push && (!full || pop);
  assign r_data = r_valid ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk)
    if (!reset && wr_en) mem[wr_ptr] <= tpu_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
      if (push && full && !pop) err <= 1'b1;
    end
  end
`else
  assign r_valid = 1'b0;
  assign r_data = 8'h00;
  assign err = 1'b0;
`endif
endmodule

// File: doc/tpu_host_driver.md
TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 Parameter RESULT_DEPTH, default 8, result FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter CAPTURE_DELAY, default 4, cycles from the start pulse to the first result sample (1..15).
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_data  input  8  host command or payload byte.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_ready  output  1  driver accepts s_data; a transfer occurs when s_valid && s_ready.
REQ-008 ui_out  output  8  byte driven to the TPU ui_in bus.
REQ-009 fetch_w / fetch_inp / fetch_ins  output  1 each  one-hot load strobes to the TPU.
REQ-010 start  output  1  TPU start pulse.
REQ-011 tpu_out  input  8  TPU wire_out result bus.
REQ-012 r_data  output  8  result FIFO head.
REQ-013 r_valid  output  1  FIFO non-empty.
REQ-014 r_ready  input  1  host pop; a pop occurs when r_valid && r_ready.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.
REQ-016 err  output  1  sticky overflow flag.

Function
REQ-017 Header byte format: bits[7:6] = op (00 weights, 01 inputs, 10 instructions, 11 run); bit 5 is ignored; n = bits[4:0]+1 (1..32).
REQ-018 FSM states are IDLE, LOAD, START, WAIT and CAPTURE.
REQ-019 IDLE: s_ready=1; an accepted header with op 00/01/10 latches op and n, then goes to LOAD; op 11 latches n as cap_cnt, then goes to START.
REQ-020 LOAD: s_ready=1; each accepted byte appears on ui_out in the next cycle, with the op-selected fetch strobe high for exactly that cycle (latency 1).
REQ-021 LOAD: after the n-th byte is accepted, the FSM returns to IDLE; gaps in s_valid hold state and drive all strobes low.
REQ-022 ui_out holds its last value when no strobe is active; at most one of fetch_w/fetch_inp/fetch_ins/start is high in any cycle.
REQ-023 START: s_ready=0; start is high for exactly one cycle; the FSM then goes to WAIT with delay counter = CAPTURE_DELAY-1.
REQ-024 WAIT: s_ready=0; the counter decrements each cycle and the FSM enters CAPTURE when it reaches 0.
REQ-025 CAPTURE: s_ready=0; tpu_out is pushed to the FIFO on each of cap_cnt consecutive cycles, then the FSM returns to IDLE.
REQ-026 The first sample is taken CAPTURE_DELAY cycles after the cycle in which start is high.
REQ-027 FIFO full with no pop in the same cycle: the push is dropped and err is set; a simultaneous pop and push when full is legal and does not set err.
REQ-028 FIFO pop and push in the same cycle when empty: only the push takes effect, and r_valid rises the next cycle.
REQ-029 r_data is the FIFO head, valid while r_valid=1; the FIFO pointers wrap modulo RESULT_DEPTH.
REQ-030 Host pops are accepted in every FSM state.
REQ-031 s_data bytes presented while s_ready=0 are not consumed.

Reset
REQ-032 With reset high at a clock edge: the FSM goes to IDLE; ui_out=0, all strobes=0, start=0, busy=0, err=0; the FIFO is emptied (r_valid=0, r_data=0); all counters are 0.
REQ-033 Reset mid-LOAD or mid-CAPTURE aborts the operation with no further strobes or pushes; s_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-034 Macro TPU_HOST_DRIVER_RESULT_EN defined: the WAIT/CAPTURE path and the FIFO are implemented as specified above.
REQ-035 Macro TPU_HOST_DRIVER_RESULT_EN undefined: the FSM goes START -> IDLE; r_valid, r_data and err are tied to 0; r_ready and tpu_out are ignored; no FIFO storage is built.

Verification
REQ-036 Header 0x01 followed by bytes 0x11, 0x22 -> ui_out=0x11 then 0x22, each with fetch_w high for one cycle; FSM back in IDLE; busy=0.
REQ-037 Header 0x40 with byte 0x7F sent with s_valid gaps -> a single fetch_inp pulse with ui_out=0x7F; no strobe during the gaps.
REQ-038 Header 0xC2 with CAPTURE_DELAY=4 and tpu_out ramping 0x00,0x01,... each cycle -> start pulses once; the FIFO receives the tpu_out values sampled 4, 5 and 6 cycles after the start cycle; r_valid=1; host pops return them in order.
REQ-039 RESULT_DEPTH=8, header 0xC9 (10 samples), r_ready=0 -> 8 bytes stored, 2 dropped, err=1 after the 9th sample; err stays 1 until reset.
REQ-040 Header 0x85 followed by 2 bytes, then reset asserted -> no fetch_ins after reset; busy=0; s_ready=1; a following header 0x00 plus 1 byte yields exactly one fetch_w pulse.
REQ-041 Build without TPU_HOST_DRIVER_RESULT_EN, header 0xC3 -> one start pulse, return to IDLE after 2 cycles, r_valid stays 0.
